pi_bus_arbiter: RTL and testbench
=================================

PI_BUS_ARBITER -- requirements
Module: pi_bus_arbiter

Interface
REQ-001 SHALL have parameter RD_LAT, default 1, cycles from pi_rd_en strobe to valid pi_rd_data (legal 1..3).
REQ-002 SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 reqN_valid  input  1  requester N (N=0,1) transaction request.
REQ-006 reqN_ready  output  1  arbiter accepts requester N this cycle.
REQ-007 reqN_wr  input  1  1=write, 0=read.
REQ-008 reqN_addr  input  4  register address.
REQ-009 reqN_wdata  input  8  write data.
REQ-010 reqN_rvalid  output  1  one-cycle pulse, read data returned.
REQ-011 reqN_rdata  output  8  read data, held until next read return to N.
REQ-012 pi_blk_sel, pi_wr_en, pi_rd_en  output  1 each  peripheral bus strobes.
REQ-013 pi_addr  output  4; pi_wr_data  output  8; pi_rd_data  input  8.
REQ-014 interrupt  input  1  level interrupt from peripheral.
REQ-015 irq_pend  output  1  latched interrupt, reported to requester 0.
REQ-016 irq_clr  input  1  requester 0 clears irq_pend; interrupt_ack  output  1  one-cycle acknowledge.

Function
REQ-017 FSM states SHALL be IDLE, WRITE, READ, RD_WAIT.
REQ-018 In IDLE, reqN_ready SHALL be combinational: high only for the granted valid requester; both low outside IDLE.
REQ-019 Grant: single valid requester wins; both valid -> requester not served last; last-served pointer resets to 1 (requester 0 wins first tie).
REQ-020 Accept (valid&ready) in cycle T SHALL register wr/addr/wdata/owner and enter WRITE or READ at T+1.
REQ-021 WRITE (T+1): pi_blk_sel=1, pi_wr_en=1, pi_addr, pi_wr_data driven; IDLE at T+2.
REQ-022 READ (T+1): pi_blk_sel=1, pi_rd_en=1, pi_addr driven; then RD_WAIT counting RD_LAT-1 cycles (0 if RD_LAT=1).
REQ-023 pi_rd_data SHALL be sampled at end of cycle T+1+RD_LAT; ownerN_rvalid pulses with reqN_rdata at T+2+RD_LAT; FSM in IDLE that same cycle (new accept allowed).
REQ-024 Outside strobe cycles pi_blk_sel, pi_wr_en, pi_rd_en, pi_addr, pi_wr_data SHALL be 0; pi_wr_en and pi_rd_en never both high.
REQ-025 Bus outputs SHALL be registered (no combinational path from reqN_* to pi_*).
REQ-026 Only one transaction outstanding; requests during busy states stall (ready low), not dropped.
REQ-027 irq_pend SHALL set the cycle after interrupt seen high, hold until irq_clr.
REQ-028 irq_clr while irq_pend=1 SHALL clear irq_pend next cycle and pulse interrupt_ack one cycle; irq_clr with irq_pend=0 ignored.
REQ-029 Simultaneous interrupt high and irq_clr: clear wins, ack pulses; irq_pend re-sets next cycle if interrupt still high.
REQ-030 reqN_valid drop before acceptance SHALL be tolerated (no transaction).

Reset
REQ-031 rst SHALL force IDLE, all pi_* outputs 0, reqN_rvalid 0, reqN_rdata 0, irq_pend 0, interrupt_ack 0, last-served pointer 1, RD_WAIT counter 0.
REQ-032 rst mid-transaction SHALL abort it: no rvalid pulse, strobes deasserted next edge.

Structure
REQ-033 Package pi_arb_pkg SHALL hold PI_ADDR_W=4, PI_DATA_W=8, state enum type.
REQ-034 One sub-module pi_rr_arb (2-way round-robin grant, last-served pointer) SHALL be used.

Verification
REQ-035 req0 write addr 3 data 0xA5 -> one cycle pi_blk_sel=pi_wr_en=1, pi_addr=3, pi_wr_data=0xA5; no rvalid.
REQ-036 req1 read addr 7, RD_LAT=1, model returns 0x3C -> pi_rd_en one cycle, req1_rvalid pulse with req1_rdata=0x3C at T+3.
REQ-037 Both valid continuously from reset, writes -> grants alternate 0,1,0,1; each write 2 cycles apart.
REQ-038 RD_LAT=3 read -> rvalid at T+5, no new accept before then while second request waits.
REQ-039 interrupt high, then irq_clr with interrupt low -> irq_pend 1 then 0, interrupt_ack single pulse.
REQ-040 rst asserted during RD_WAIT -> strobes 0, no rvalid, next request handled normally with req0 priority.

Source files
------------

// File: rtl/pi_arb_pkg.sv
// pi_arb_pkg: shared widths and FSM state type for the peripheral bus arbiter
package pi_arb_pkg;
  localparam int PI_ADDR_W = 4;
  localparam int PI_DATA_W = 8;
  typedef enum logic [1:0] {IDLE, WRITE, READ, RD_WAIT} state_t;
endpackage

// File: rtl/pi_rr_arb.sv
// pi_rr_arb: 2-way round-robin grant with a last-served pointer
module pi_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);
  logic last, pick1;
  always_comb begin
    pick1 = valid[1] & (~valid[0] | ~last);
    grant = en ? {pick1, valid[0] & ~pick1} : 2'b00;
  end
  always_ff @(posedge clk)
    if (rst) last <= 1'b1;
    else if (|grant) last <= grant[1];
endmodule

// File: rtl/pi_bus_arbiter.sv
// pi_bus_arbiter: two requesters share one registered peripheral bus; one
// transaction in flight, read data returned RD_LAT cycles after the strobe.
module pi_bus_arbiter
  import pi_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_wr,
  input  logic [PI_ADDR_W-1:0] req0_addr,
  input  logic [PI_DATA_W-1:0] req0_wdata,
  output logic                 req0_rvalid,
  output logic [PI_DATA_W-1:0] req0_rdata,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_wr,
  input  logic [PI_ADDR_W-1:0] req1_addr,
  input  logic [PI_DATA_W-1:0] req1_wdata,
  output logic                 req1_rvalid,
  output logic [PI_DATA_W-1:0] req1_rdata,
  output logic                 pi_blk_sel,
  output logic                 pi_wr_en,
  output logic                 pi_rd_en,
  output logic [PI_ADDR_W-1:0] pi_addr,
  output logic [PI_DATA_W-1:0] pi_wr_data,
  input  logic [PI_DATA_W-1:0] pi_rd_data,
  input  logic                 interrupt,
  output logic                 irq_pend,
  input  logic                 irq_clr,
  output logic                 interrupt_ack
);
  localparam logic [1:0] CNT_LAST = 2'(RD_LAT - 1);
  state_t state, state_nx;
  logic [1:0] grant;
  logic [1:0] cnt;
  logic owner, accept, rd_done, sel_wr;
  logic [PI_ADDR_W-1:0] sel_addr;
  logic [PI_DATA_W-1:0] sel_wdata;
  pi_rr_arb u_arb (
    .clk  (clk),
    .rst  (rst),
    .en   (state == IDLE),
    .valid({req1_valid, req0_valid}),
    .grant(grant)
  );
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  always_comb begin
    accept    = |grant;
    sel_wr    = grant[1] ? req1_wr : req0_wr;
    sel_addr  = grant[1] ? req1_addr : req0_addr;
    sel_wdata = grant[1] ? req1_wdata : req0_wdata;
    rd_done   = (state == RD_WAIT) && (cnt == CNT_LAST);
    state_nx  = state == IDLE  ? (accept ? (sel_wr ? WRITE : READ) : IDLE) :
                state == WRITE ? IDLE :
                state == READ  ? RD_WAIT :
                rd_done        ? IDLE : RD_WAIT;
  end
  // Strobes are loaded on accept and live exactly one cycle.
  always_ff @(posedge clk)
    if (rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      cnt         <= '0;
      pi_blk_sel  <= 1'b0;
      pi_wr_en    <= 1'b0;
      pi_rd_en    <= 1'b0;
      pi_addr     <= '0;
      pi_wr_data  <= '0;
      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;
      req0_rdata  <= '0;
      req1_rdata  <= '0;
    end else begin
      state       <= state_nx;
      if (accept) owner <= grant[1];
      cnt         <= (state == RD_WAIT && !rd_done) ? cnt + 2'd1 : '0;
      pi_blk_sel  <= accept;
      pi_wr_en    <= accept & sel_wr;
      pi_rd_en    <= accept & ~sel_wr;
      pi_addr     <= accept ? sel_addr : '0;
      pi_wr_data  <= (accept & sel_wr) ? sel_wdata : '0;
      req0_rvalid <= rd_done & ~owner;
      req1_rvalid <= rd_done & owner;
      if (rd_done & ~owner) req0_rdata <= pi_rd_data;
      if (rd_done & owner) req1_rdata <= pi_rd_data;
    end
  // A clear request beats a fresh interrupt in the same cycle.
  always_ff @(posedge clk)
    if (rst) begin
      irq_pend      <= 1'b0;
      interrupt_ack <= 1'b0;
    end else if (irq_clr && irq_pend) begin
      irq_pend      <= 1'b0;
      interrupt_ack <= 1'b1;
    end else begin
      irq_pend      <= irq_pend | interrupt;
      interrupt_ack <= 1'b0;
    end
endmodule

// File: tb/tb_pi_bus_arbiter.sv
// tb_pi_bus_arbiter: directed checks on RD_LAT=1 and RD_LAT=3 instances
module tb_pi_bus_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid = 0, req0_wr = 0, req1_valid = 0, req1_wr = 0;
  logic [3:0] req0_addr = 0, req1_addr = 0;
  logic [7:0] req0_wdata = 0, req1_wdata = 0;
  logic interrupt = 0, irq_clr = 0;
  logic [1:0] rdy1, rdy3, rv1, rv3;
  logic [7:0] rd1_0, rd1_1, rd3_0, rd3_1, wd1, wd3, pd1, pd3;
  logic [3:0] ad1, ad3, al1, al3;
  logic blk1, blk3, we1, we3, re1, re3, pend1, pend3, ack1, ack3, d1;
  logic [2:0] sr3;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  pi_bus_arbiter #(.RD_LAT(1)) u1 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(rdy1[0]), .req0_wr(req0_wr), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_rvalid(rv1[0]), .req0_rdata(rd1_0),
    .req1_valid(req1_valid), .req1_ready(rdy1[1]), .req1_wr(req1_wr), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_rvalid(rv1[1]), .req1_rdata(rd1_1),
    .pi_blk_sel(blk1), .pi_wr_en(we1), .pi_rd_en(re1), .pi_addr(ad1), .pi_wr_data(wd1),
    .pi_rd_data(pd1), .interrupt(interrupt), .irq_pend(pend1), .irq_clr(irq_clr),
    .interrupt_ack(ack1)
  );
  pi_bus_arbiter #(.RD_LAT(3)) u3 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(rdy3[0]), .req0_wr(req0_wr), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_rvalid(rv3[0]), .req0_rdata(rd3_0),
    .req1_valid(req1_valid), .req1_ready(rdy3[1]), .req1_wr(req1_wr), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_rvalid(rv3[1]), .req1_rdata(rd3_1),
    .pi_blk_sel(blk3), .pi_wr_en(we3), .pi_rd_en(re3), .pi_addr(ad3), .pi_wr_data(wd3),
    .pi_rd_data(pd3), .interrupt(interrupt), .irq_pend(pend3), .irq_clr(irq_clr),
    .interrupt_ack(ack3)
  );
  // Peripheral model: data 0x35+addr valid only in the cycle RD_LAT after the strobe.
  always @(posedge clk) begin
    d1  <= re1;
    sr3 <= {sr3[1:0], re3};
    if (re1) al1 <= ad1;
    if (re3) al3 <= ad3;
  end
  assign pd1 = d1 ? 8'h35 + {4'h0, al1} : 8'hEE;
  assign pd3 = sr3[2] ? 8'h35 + {4'h0, al3} : 8'hEE;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  initial begin
    d1 = 0; sr3 = 0; al1 = 0; al3 = 0;
    req0_valid = 1; req0_wr = 1; req0_addr = 1; req0_wdata = 8'h11;
    req1_valid = 1; req1_wr = 1; req1_addr = 2; req1_wdata = 8'h22;
    repeat (2) step;
    check("rst_blk", blk1, 0);
    check("rst_strobes", {we1, re1, we3, re3}, 0);
    check("rst_addr", ad1, 0);
    check("rst_rvalid", {rv1, rv3}, 0);
    check("rst_rdata", {rd1_0, rd1_1}, 0);
    check("rst_irq", {pend1, ack1}, 0);
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      #1 check("rr_grant", rdy1, (k % 2) ? 2'b10 : 2'b01);
      step;
      check("rr_wr_en", {blk1, we1, re1}, 3'b110);
      check("rr_addr", ad1, (k % 2) ? 2 : 1);
      check("rr_wdata", wd1, (k % 2) ? 8'h22 : 8'h11);
      check("rr_busy_ready", rdy1, 0);
      step;
      check("rr_idle_blk", blk1, 0);
    end
    req0_valid = 0; req1_valid = 0;
    req0_addr = 3; req0_wdata = 8'hA5; req0_valid = 1;
    #1 check("w_ready", rdy1, 2'b01);
    step;
    req0_valid = 0;
    check("w_strobe", {blk1, we1, re1}, 3'b110);
    check("w_addr", ad1, 3);
    check("w_data", wd1, 8'hA5);
    step;
    check("w_after", {blk1, we1, re1, ad1, wd1}, 0);
    check("w_no_rvalid", rv1, 0);
    req1_wr = 0; req1_addr = 7; req1_valid = 1;
    #1 check("r_ready", rdy1, 2'b10);
    step;
    req1_valid = 0;
    check("r_strobe", {blk1, we1, re1}, 3'b101);
    check("r_addr", ad1, 7);
    step;
    check("r_wait", {re1, rv1}, 0);
    step;
    check("r_rvalid", rv1, 2'b10);
    check("r_rdata", rd1_1, 8'h3C);
    step;
    check("r_rvalid_off", rv1, 0);
    check("r_rdata_hold", rd1_1, 8'h3C);
    step;
    check("r3_rvalid", rv3, 2'b10);
    check("r3_rdata", rd3_1, 8'h3C);
    step;
    req0_wr = 0; req0_addr = 4; req0_valid = 1;
    req1_wr = 1; req1_addr = 9; req1_wdata = 8'h99; req1_valid = 1;
    #1 check("l3_grant", rdy3, 2'b01);
    step;
    req0_valid = 0;
    check("l3_strobe", {re3, ad3}, {1'b1, 4'h4});
    for (int i = 0; i < 3; i++) begin
      step;
      check("l3_stall", {rdy3, blk3}, 0);
    end
    step;
    check("l3_rvalid", rv3, 2'b01);
    check("l3_rdata", rd3_0, 8'h39);
    #1 check("l3_next_grant", rdy3, 2'b10);
    step;
    req1_valid = 0;
    check("l3_wr", {we3, ad3, wd3}, {1'b1, 4'h9, 8'h99});
    repeat (2) step;
    interrupt = 1;
    step;
    check("irq_set", {pend1, ack1, pend3}, 3'b101);
    interrupt = 0;
    step;
    check("irq_hold", {pend1, ack1}, 2'b10);
    irq_clr = 1;
    step;
    check("irq_clr", {pend1, ack1}, 2'b01);
    irq_clr = 0;
    step;
    check("irq_ack_once", {pend1, ack1}, 2'b00);
    interrupt = 1;
    step;
    check("irq_set2", pend1, 1);
    irq_clr = 1;
    step;
    check("irq_clr_wins", {pend1, ack1}, 2'b01);
    irq_clr = 0;
    step;
    check("irq_reset", {pend1, ack1}, 2'b10);
    interrupt = 0; irq_clr = 1;
    step;
    check("irq_clr3", {pend1, ack1}, 2'b01);
    step;
    check("irq_clr_ignored", {pend1, ack1}, 2'b00);
    irq_clr = 0;
    req1_wr = 0; req1_addr = 2; req1_valid = 1;
    step;
    req1_valid = 0;
    check("a_strobe", re3, 1);
    step;
    rst = 1;
    step;
    rst = 0;
    check("a_strobes", {blk3, re3, we3, blk1, re1}, 0);
    check("a_rvalid", {rv3, rv1}, 0);
    check("a_rdata", {rd3_0, rd1_1}, 0);
    for (int i = 0; i < 4; i++) begin
      step;
      check("a_no_rvalid", {rv3, rv1}, 0);
    end
    req0_wr = 1; req0_addr = 5; req0_valid = 1;
    req1_wr = 1; req1_addr = 6; req1_valid = 1;
    #1 check("a_prio", rdy3, 2'b01);
    step;
    req0_valid = 0; req1_valid = 0;
    check("a_next", {we3, ad3}, {1'b1, 4'h5});
    step;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
